uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
- Next-generation UART receiver. Parametrised maximum word width and oversampling ratio.
- Runtime-configurable character format: data bits, parity none/even/odd, 1 or 2 stop bits.
- Adds input synchronisation, 3-sample majority voting, break wait, and a valid/ready output holding register with overrun reporting.
- Sits between the pad-side serial line and the host-side receive interface; driven by a shared baud sample-tick generator.

Parameters:
- DATA_MAX, 9, maximum data bits per character (legal 5..9); width of data_out.
- OVERSAMPLE, 16, sample_tick pulses per bit period (even, 8..32).
- SYNC_STAGES, 2, flops in rx_serial_in synchroniser (>=2).

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-high reset.
- sample_tick  input  1  one-cycle enable at OVERSAMPLE x baud rate.
- rx_serial_in  input  1  asynchronous serial line, idle high.
- rx_enable  input  1  0 = receiver held in IDLE, no start detection.
- cfg_data_bits  input  4  data bits per character, 5..DATA_MAX; out-of-range values clamp to DATA_MAX.
- cfg_parity_en  input  1  parity bit present.
- cfg_parity_odd  input  1  1 = odd, 0 = even parity.
- cfg_two_stop  input  1  1 = two stop bits.
- data_out  output  DATA_MAX  received word, LSB-aligned, unused upper bits 0.
- data_valid  output  1  holding register full.
- data_ready  input  1  consumer accepts when data_valid and data_ready are both 1.
- parity_error  output  1  status of held word; qualified by data_valid.
- frame_error  output  1  status of held word; qualified by data_valid.
- break_error  output  1  status of held word; qualified by data_valid.
- overrun_error  output  1  one-cycle pulse: completed frame dropped.
- rx_busy  output  1  state is not IDLE.

Behaviour:
- Reset state: all outputs 0; state IDLE; synchroniser flops 1; counters 0. Reset mid-frame aborts the frame immediately; any held word is discarded.
- Sample counter advances only on sample_tick. "mid" is tick OVERSAMPLE/2 of a bit. Each bit value is the majority of the samples at mid-1, mid, and mid+1.
- Config inputs are latched on start-edge detection; changes mid-frame have no effect until the next frame.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT.
- IDLE -> START: rx_enable=1 and synchronised line = 0 on a sample_tick. The counter is cleared at that tick.
- START: the voted bit is evaluated at mid+1.
  - If the vote is 1 (glitch), go to IDLE with no output.
  - Otherwise go to DATA, with bit timing re-aligned so later bits are evaluated every OVERSAMPLE ticks.
- DATA: shift in LSB first, cfg_data_bits bits. Then go to PARITY if cfg_parity_en=1, else STOP1.
- PARITY: expected bit is XOR of the data bits, inverted when odd. A mismatch sets the parity_error candidate.
- STOP1:
  - Vote 0 with all data bits 0 and parity bit 0 (or parity disabled): break. Set break_error (frame_error and parity_error forced 0), then go to BRK_WAIT.
  - Vote 0 otherwise: frame_error, then go to IDLE.
  - Vote 1: go to STOP2 if cfg_two_stop=1, else IDLE.
- STOP2: vote 0 -> frame_error. Then go to IDLE.
- BRK_WAIT: stays until the synchronised line reads 1 on a sample_tick, then goes to IDLE. No start detection in this state.
- Completion: one clk after the final stop vote (or the break decision), the frame is offered to the holding register.
  - Offered frames include errored frames; status bits travel with the word.
  - Register empty, or emptying in this same cycle (data_valid & data_ready): load it, data_valid=1.
  - Otherwise: drop the new frame, pulse overrun_error for 1 cycle; the held word and its status are unchanged.
- data_valid stays high until a handshake. data_out and status hold stable while data_valid=1.
- rx_enable=0 mid-frame: the current frame completes normally. The enable only gates IDLE -> START.
- A falling edge during STOP1/STOP2 before mid is ignored; start detection happens only in IDLE.
- Latency: line input to sampled value is SYNC_STAGES clk.

Test Plan:
- 8N1, OVERSAMPLE=16, tick every clk, send 0xA5, data_ready=1 -> data_valid for 1 cycle, data_out=0x0A5, all errors 0.
- 7E2, send 0x3C with a correct parity bit, then the same with the parity bit flipped -> first word parity_error=0, second word parity_error=1, both delivered.
- 8N1, line low for 4 ticks then high -> no data_valid, returns to IDLE, rx_busy back to 0. A single-tick glitch at mid of a data bit is voted out and the word is correct.
- 8O1, stop bit driven 0 with data 0x55 -> frame_error=1. Line held low for 2 full frames -> single word with break_error=1 and data_out=0; no new start until the line is high.
- data_ready=0, send 0x11 then 0x22 -> data_out stays 0x011, overrun_error pulses once. Then data_ready=1 -> handshake, data_valid falls.
- Assert reset during DATA bit 3 -> all outputs 0 next cycle; the next clean frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with a runtime character format
// (5..DATA_MAX data bits, optional even/odd parity, 1 or 2 stop bits),
// 3-sample majority voting per bit, break detection, and a valid/ready
// holding register that reports frames dropped while it is still full.
module uart_rx_cfg #(
  parameter int DATA_MAX    = 9,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_tick,
  input  logic                rx_serial_in,
  input  logic                rx_enable,
  input  logic [3:0]          cfg_data_bits,
  input  logic                cfg_parity_en,
  input  logic                cfg_parity_odd,
  input  logic                cfg_two_stop,
  output logic [DATA_MAX-1:0] data_out,
  output logic                data_valid,
  input  logic                data_ready,
  output logic                parity_error,
  output logic                frame_error,
  output logic                break_error,
  output logic                overrun_error,
  output logic                rx_busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  // Bit-relative tick indices: the tick that detected the start edge is 0.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] MID_M1   = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] MID      = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] MID_P1   = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]       DMAX_4   = 4'(DATA_MAX);
  localparam logic [3:0]       DMIN_4   = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP1    = 3'd4,
    ST_STOP2    = 3'd5,
    ST_BRK_WAIT = 3'd6
  } state_t;

  // Majority of three samples taken around the middle of a bit.
  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Even parity over the received data; unused positions are always zero.
  function automatic logic parity_of(input logic [DATA_MAX-1:0] d);
    return ^d;
  endfunction

  state_t                state_r;
  state_t                state_next_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                  line_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_inc_s;
  logic                  samp_a_r;
  logic                  samp_b_r;
  logic                  vote_s;
  logic [3:0]            cfg_bits_s;
  logic [3:0]            bits_r;
  logic                  par_en_r;
  logic                  par_odd_r;
  logic                  two_stop_r;
  logic [3:0]            bit_cnt_r;
  logic [DATA_MAX-1:0]   shift_r;
  logic [DATA_MAX-1:0]   data_align_s;
  logic                  par_bit_r;
  logic                  par_err_r;
  logic                  start_s;
  logic                  in_frame_s;
  logic                  eval_s;
  logic                  last_data_s;
  logic                  is_break_s;
  logic                  done_r;
  logic                  cand_pe_r;
  logic                  cand_fe_r;
  logic                  cand_be_r;
  logic [DATA_MAX-1:0]   hold_data_r;
  logic                  hold_valid_r;
  logic                  hold_pe_r;
  logic                  hold_fe_r;
  logic                  hold_be_r;
  logic                  ovr_r;
  logic                  busy_r;

  assign line_s       = sync_r[SYNC_STAGES-1];
  assign vote_s       = vote3(samp_a_r, samp_b_r, line_s);
  assign last_data_s  = (bit_cnt_r == (bits_r - 4'd1));
  assign is_break_s   = (shift_r == {DATA_MAX{1'b0}}) && (!par_en_r || !par_bit_r);
  // Bits were shifted in from the top, so short words sit in the upper bits.
  assign data_align_s = shift_r >> (DMAX_4 - bits_r);

  assign data_out      = hold_data_r;
  assign data_valid    = hold_valid_r;
  assign parity_error  = hold_pe_r;
  assign frame_error   = hold_fe_r;
  assign break_error   = hold_be_r;
  assign overrun_error = ovr_r;
  assign rx_busy       = busy_r;

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], rx_serial_in};
    end
  end

  // Clamp an out-of-range character length to the widest supported word.
  always_comb begin
    if ((cfg_data_bits < DMIN_4) || (cfg_data_bits > DMAX_4)) begin
      cfg_bits_s = DMAX_4;
    end else begin
      cfg_bits_s = cfg_data_bits;
    end
  end

  // Bit-relative tick counter wraps every OVERSAMPLE ticks, which keeps
  // every later bit evaluated one bit period after the previous one.
  always_comb begin
    if (cnt_r == CNT_LAST) begin
      cnt_inc_s = {CNT_W{1'b0}};
    end else begin
      cnt_inc_s = cnt_r + CNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; every bit decision happens on the mid+1 tick.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (eval_s) begin
          state_next_s = vote_s ? ST_IDLE : ST_DATA;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (eval_s && last_data_s) begin
          state_next_s = par_en_r ? ST_PARITY : ST_STOP1;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (eval_s) begin
          state_next_s = ST_STOP1;
        end else begin
          state_next_s = ST_PARITY;
        end
      end
      ST_STOP1: begin
        if (eval_s) begin
          if (!vote_s) begin
            state_next_s = is_break_s ? ST_BRK_WAIT : ST_IDLE;
          end else begin
            state_next_s = two_stop_r ? ST_STOP2 : ST_IDLE;
          end
        end else begin
          state_next_s = ST_STOP1;
        end
      end
      ST_STOP2: begin
        if (eval_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_STOP2;
        end
      end
      ST_BRK_WAIT: begin
        if (sample_tick && line_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_BRK_WAIT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM output decode: start detection, in-frame timing and bit evaluation.
  always_comb begin
    start_s    = 1'b0;
    in_frame_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        start_s = sample_tick & rx_enable & ~line_s;
      end
      ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2: begin
        in_frame_s = 1'b1;
      end
      default: begin
        start_s    = 1'b0;
        in_frame_s = 1'b0;
      end
    endcase
    eval_s = in_frame_s & sample_tick & (cnt_inc_s == MID_P1);
  end

  // Busy flag tracks the state register without a combinational output path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != ST_IDLE);
    end
  end

  // Receive datapath: config latch, sampling, shifting and frame status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r      <= {CNT_W{1'b0}};
      samp_a_r   <= 1'b0;
      samp_b_r   <= 1'b0;
      bits_r     <= 4'd0;
      par_en_r   <= 1'b0;
      par_odd_r  <= 1'b0;
      two_stop_r <= 1'b0;
      bit_cnt_r  <= 4'd0;
      shift_r    <= {DATA_MAX{1'b0}};
      par_bit_r  <= 1'b0;
      par_err_r  <= 1'b0;
      done_r     <= 1'b0;
      cand_pe_r  <= 1'b0;
      cand_fe_r  <= 1'b0;
      cand_be_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start_s) begin
        cnt_r      <= {CNT_W{1'b0}};
        bit_cnt_r  <= 4'd0;
        shift_r    <= {DATA_MAX{1'b0}};
        par_bit_r  <= 1'b0;
        par_err_r  <= 1'b0;
        bits_r     <= cfg_bits_s;
        par_en_r   <= cfg_parity_en;
        par_odd_r  <= cfg_parity_odd;
        two_stop_r <= cfg_two_stop;
      end else if (in_frame_s && sample_tick) begin
        cnt_r <= cnt_inc_s;
        if (cnt_inc_s == MID_M1) begin
          samp_a_r <= line_s;
        end
        if (cnt_inc_s == MID) begin
          samp_b_r <= line_s;
        end
        if (eval_s) begin
          case (state_r)
            ST_DATA: begin
              shift_r   <= {vote_s, shift_r[DATA_MAX-1:1]};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
            ST_PARITY: begin
              par_bit_r <= vote_s;
              par_err_r <= vote_s ^ parity_of(shift_r) ^ par_odd_r;
            end
            ST_STOP1: begin
              if (!vote_s) begin
                done_r <= 1'b1;
                if (is_break_s) begin
                  cand_be_r <= 1'b1;
                  cand_fe_r <= 1'b0;
                  cand_pe_r <= 1'b0;
                end else begin
                  cand_be_r <= 1'b0;
                  cand_fe_r <= 1'b1;
                  cand_pe_r <= par_err_r;
                end
              end else if (!two_stop_r) begin
                done_r    <= 1'b1;
                cand_be_r <= 1'b0;
                cand_fe_r <= 1'b0;
                cand_pe_r <= par_err_r;
              end
            end
            ST_STOP2: begin
              done_r    <= 1'b1;
              cand_be_r <= 1'b0;
              cand_fe_r <= ~vote_s;
              cand_pe_r <= par_err_r;
            end
            default: begin
              done_r <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Holding register: accept a completed frame when empty or draining,
  // otherwise drop it and flag an overrun for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data_r  <= {DATA_MAX{1'b0}};
      hold_valid_r <= 1'b0;
      hold_pe_r    <= 1'b0;
      hold_fe_r    <= 1'b0;
      hold_be_r    <= 1'b0;
      ovr_r        <= 1'b0;
    end else begin
      ovr_r <= 1'b0;
      if (done_r) begin
        if (!hold_valid_r || data_ready) begin
          hold_data_r  <= data_align_s;
          hold_valid_r <= 1'b1;
          hold_pe_r    <= cand_pe_r;
          hold_fe_r    <= cand_fe_r;
          hold_be_r    <= cand_be_r;
        end else begin
          ovr_r <= 1'b1;
        end
      end else if (hold_valid_r && data_ready) begin
        hold_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: directed scenarios plus randomized frames,
// checked against a frame-level reference model and expected-word queue.
module tb_uart_rx_cfg;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic       rx_serial_in;
  logic       rx_enable;
  logic [3:0] cfg_data_bits;
  logic       cfg_parity_en;
  logic       cfg_parity_odd;
  logic       cfg_two_stop;
  logic [8:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       parity_error;
  logic       frame_error;
  logic       break_error;
  logic       overrun_error;
  logic       rx_busy;

  always #5 clk = ~clk;

  uart_rx_cfg #(.DATA_MAX(9), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_tick   (sample_tick),
    .rx_serial_in  (rx_serial_in),
    .rx_enable     (rx_enable),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity_en (cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd),
    .cfg_two_stop  (cfg_two_stop),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .parity_error  (parity_error),
    .frame_error   (frame_error),
    .break_error   (break_error),
    .overrun_error (overrun_error),
    .rx_busy       (rx_busy)
  );

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       be;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_checks     = 0;
  int n_errors     = 0;
  int hs_count     = 0;
  int valid_cycles = 0;
  int ovr_count    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int eff_bits(input logic [3:0] b);
    if (b < 4'd5 || b > 4'd9) return 9;
    else return int'(b);
  endfunction

  // Reference model: what a frame as transmitted should deliver.
  task automatic expect_frame(input logic [3:0] raw_bits, input bit par_en, input bit odd,
                              input logic [8:0] d, input bit flip, input bit bad_stop);
    exp_t e;
    int nb;
    logic [8:0] dd;
    logic pexp;
    logic sent;
    nb   = eff_bits(raw_bits);
    dd   = d & 9'((1 << nb) - 1);
    pexp = (^dd) ^ odd;
    sent = flip ? ~pexp : pexp;
    e.d  = dd;
    e.pe = par_en & flip;
    e.fe = 1'b0;
    e.be = 1'b0;
    if (bad_stop) begin
      if (dd == 9'd0 && (!par_en || !sent)) begin
        e.be = 1'b1;
        e.pe = 1'b0;
      end else begin
        e.fe = 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic hold_line(input logic v, input int n);
    rx_serial_in = v;
    repeat (n) @(negedge clk);
  endtask

  // Serialise one character; optional glitch, mid-frame config scramble and enable modes.
  task automatic send_frame(input logic [3:0] raw_bits, input bit par_en, input bit odd, input bit two,
                            input logic [8:0] d, input bit flip, input bit bad_stop,
                            input int glitch_bit, input bit scramble, input int en_mode);
    int nb;
    logic pbit;
    nb   = eff_bits(raw_bits);
    pbit = odd ^ flip;
    for (int i = 0; i < nb; i++) pbit = pbit ^ d[i];
    cfg_data_bits  = raw_bits;
    cfg_parity_en  = par_en;
    cfg_parity_odd = odd;
    cfg_two_stop   = two;
    rx_enable      = (en_mode != 1);
    hold_line(1'b0, OS / 2);
    if (scramble) begin
      cfg_data_bits  = 4'($urandom_range(0, 15));
      cfg_parity_en  = ~par_en;
      cfg_parity_odd = ~odd;
      cfg_two_stop   = ~two;
    end
    if (en_mode == 2) rx_enable = 1'b0;
    hold_line(1'b0, OS / 2);
    for (int i = 0; i < nb; i++) begin
      if (i == glitch_bit) begin
        hold_line(d[i], 8);
        hold_line(~d[i], 1);
        hold_line(d[i], OS - 9);
      end else begin
        hold_line(d[i], OS);
      end
    end
    if (par_en) hold_line(pbit, OS);
    hold_line(bad_stop ? 1'b0 : 1'b1, OS);
    if (two) hold_line(1'b1, OS);
    hold_line(1'b1, 8);
    rx_enable = 1'b1;
  endtask

  // Consumer-side monitor: scores every handshake against the expected queue.
  always @(negedge clk) begin
    #1;
    if (data_valid) valid_cycles++;
    if (overrun_error) ovr_count++;
    if (data_valid && data_ready) begin
      hs_count++;
      check_eq("word_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check_eq("word_data", 32'(data_out), 32'(mon_e.d));
        check_eq("word_parity_err", 32'(parity_error), 32'(mon_e.pe));
        check_eq("word_frame_err", 32'(frame_error), 32'(mon_e.fe));
        check_eq("word_break_err", 32'(break_error), 32'(mon_e.be));
      end
    end
  end

  initial begin
    int hs0, vc0, ov0, nb, gb, en_mode;
    logic [3:0] raw;
    logic [8:0] d;
    bit par, odd, two, flip, bad, scr;

    reset          = 1'b1;
    sample_tick    = 1'b1;
    rx_serial_in   = 1'b1;
    rx_enable      = 1'b1;
    cfg_data_bits  = 4'd8;
    cfg_parity_en  = 1'b0;
    cfg_parity_odd = 1'b0;
    cfg_two_stop   = 1'b0;
    data_ready     = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_data_out", 32'(data_out), 32'd0);
    check_eq("rst_valid", 32'(data_valid), 32'd0);
    check_eq("rst_errors", 32'({parity_error, frame_error, break_error, overrun_error}), 32'd0);
    check_eq("rst_busy", 32'(rx_busy), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 0xA5 with the consumer always ready
    hs0 = hs_count; vc0 = valid_cycles;
    expect_frame(4'd8, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0);
    send_frame(4'd8, 1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0, -1, 1'b0, 0);
    check_eq("a5_handshakes", 32'(hs_count - hs0), 32'd1);
    check_eq("a5_valid_cycles", 32'(valid_cycles - vc0), 32'd1);

    // 7E2: good parity, then flipped parity bit
    expect_frame(4'd7, 1'b1, 1'b0, 9'h03C, 1'b0, 1'b0);
    send_frame(4'd7, 1'b1, 1'b0, 1'b1, 9'h03C, 1'b0, 1'b0, -1, 1'b0, 0);
    expect_frame(4'd7, 1'b1, 1'b0, 9'h03C, 1'b1, 1'b0);
    send_frame(4'd7, 1'b1, 1'b0, 1'b1, 9'h03C, 1'b1, 1'b0, -1, 1'b0, 0);

    // Short low pulse is rejected as a glitch start
    hs0 = hs_count;
    cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_two_stop = 1'b0;
    hold_line(1'b0, 4);
    check_eq("glitch_start_busy", 32'(rx_busy), 32'd1);
    hold_line(1'b1, 3 * OS);
    check_eq("glitch_start_idle", 32'(rx_busy), 32'd0);
    check_eq("glitch_start_no_word", 32'(hs_count - hs0), 32'd0);

    // One-tick glitch mid data bit is voted out
    expect_frame(4'd8, 1'b0, 1'b0, 9'h05A, 1'b0, 1'b0);
    send_frame(4'd8, 1'b0, 1'b0, 1'b0, 9'h05A, 1'b0, 1'b0, 2, 1'b0, 0);

    // 8O1 with a low stop bit: frame error
    expect_frame(4'd8, 1'b1, 1'b1, 9'h055, 1'b0, 1'b1);
    send_frame(4'd8, 1'b1, 1'b1, 1'b0, 9'h055, 1'b0, 1'b1, -1, 1'b0, 0);
    hold_line(1'b1, OS);

    // Line held low for two frames: one break word, then wait for idle
    hs0 = hs_count;
    cfg_data_bits = 4'd8; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b1; cfg_two_stop = 1'b0;
    mon_e.d = 9'd0; mon_e.pe = 1'b0; mon_e.fe = 1'b0; mon_e.be = 1'b1;
    exp_q.push_back(mon_e);
    hold_line(1'b0, 2 * 11 * OS);
    check_eq("break_single_word", 32'(hs_count - hs0), 32'd1);
    check_eq("break_wait_busy", 32'(rx_busy), 32'd1);
    hold_line(1'b1, 20);
    check_eq("break_released", 32'(rx_busy), 32'd0);

    // Overrun: consumer stalled, second frame dropped
    data_ready = 1'b0;
    hs0 = hs_count; ov0 = ovr_count;
    expect_frame(4'd8, 1'b0, 1'b0, 9'h011, 1'b0, 1'b0);
    send_frame(4'd8, 1'b0, 1'b0, 1'b0, 9'h011, 1'b0, 1'b0, -1, 1'b0, 0);
    send_frame(4'd8, 1'b0, 1'b0, 1'b0, 9'h022, 1'b0, 1'b0, -1, 1'b0, 0);
    check_eq("ovr_held_data", 32'(data_out), 32'h011);
    check_eq("ovr_held_valid", 32'(data_valid), 32'd1);
    check_eq("ovr_pulses", 32'(ovr_count - ov0), 32'd1);
    data_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("ovr_drained_valid", 32'(data_valid), 32'd0);
    check_eq("ovr_handshakes", 32'(hs_count - hs0), 32'd1);

    // Reset during data bit 3 discards the held word and the frame
    data_ready = 1'b0;
    send_frame(4'd8, 1'b0, 1'b0, 1'b0, 9'h033, 1'b0, 1'b0, -1, 1'b0, 0);
    check_eq("pre_reset_held", 32'(data_valid), 32'd1);
    hold_line(1'b0, OS);
    hold_line(1'b0, OS);
    hold_line(1'b1, OS);
    hold_line(1'b1, OS);
    hold_line(1'b0, 8);
    reset = 1'b1;
    #1;
    check_eq("midrst_valid", 32'(data_valid), 32'd0);
    check_eq("midrst_data", 32'(data_out), 32'd0);
    check_eq("midrst_busy", 32'(rx_busy), 32'd0);
    check_eq("midrst_errors", 32'({parity_error, frame_error, break_error, overrun_error}), 32'd0);
    hold_line(1'b1, 3);
    reset = 1'b0;
    hold_line(1'b1, 20);
    data_ready = 1'b1;
    expect_frame(4'd8, 1'b0, 1'b0, 9'h07E, 1'b0, 1'b0);
    send_frame(4'd8, 1'b0, 1'b0, 1'b0, 9'h07E, 1'b0, 1'b0, -1, 1'b0, 0);

    // Randomized formats, payloads, errors, glitches and enable behaviour
    for (int k = 0; k < 40; k++) begin
      raw  = 4'($urandom_range(0, 15));
      par  = bit'($urandom_range(0, 1));
      odd  = bit'($urandom_range(0, 1));
      two  = bit'($urandom_range(0, 1));
      d    = 9'($urandom);
      if ($urandom_range(0, 9) == 0) d = 9'd0;
      flip = par && ($urandom_range(0, 3) == 0);
      bad  = ($urandom_range(0, 6) == 0);
      scr  = bit'($urandom_range(0, 1));
      nb   = eff_bits(raw);
      gb   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      en_mode = ($urandom_range(0, 5) == 0) ? 1 : (($urandom_range(0, 4) == 0) ? 2 : 0);
      if (en_mode != 1) expect_frame(raw, par, odd, d, flip, bad);
      send_frame(raw, par, odd, two, d, flip, bad, gb, scr, en_mode);
      hold_line(1'b1, int'($urandom_range(0, 10)));
    end

    hold_line(1'b1, 50);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
